// File: rtl/vga_fb_arbiter.sv
// Arbitrates a single-port frame-buffer RAM between VGA display fetch and a pixel writer.
// Display wins during active video; the writer gets a forced slot after STARVE_MAX denials in blanking.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              blank,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_gnt,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [15:0]       w_stall_cnt
);

  typedef enum logic [1:0] {IDLE, DISP, WR} state_t;

  state_t        state_q, state_d;
  logic [7:0]    starve_q;
  logic          forced_wr;
  logic [RD_LAT:0] rd_pipe;

  always_comb begin
    forced_wr = w_req && d_req && blank && (starve_q == 8'(STARVE_MAX));
    d_gnt     = 1'b0;
    w_gnt     = 1'b0;
    state_d   = IDLE;
    if (!sys_rst) begin
      if (forced_wr)  w_gnt = 1'b1;
      else if (d_req) d_gnt = 1'b1;
      else if (w_req) w_gnt = 1'b1;
    end
    if (d_gnt)      state_d = DISP;
    else if (w_gnt) state_d = WR;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      w_stall_cnt <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
      rd_pipe     <= '0;
    end else begin
      state_q <= state_d;
      if (w_gnt || !w_req)
        starve_q <= '0;
      else if (starve_q != 8'(STARVE_MAX))
        starve_q <= starve_q + 8'd1;
      if (w_req && !w_gnt && (w_stall_cnt != '1))
        w_stall_cnt <= w_stall_cnt + 16'd1;
      if (state_d == DISP)
        m_addr <= d_addr;
      if (state_d == WR) begin
        m_addr  <= w_addr;
        m_wdata <= w_data;
      end
      // Stage 0 marks a read issued next cycle, so stage RD_LAT lines up with m_rdata.
      rd_pipe <= {rd_pipe[RD_LAT-1:0], (state_d == DISP)};
    end
  end

  assign m_en     = (state_q != IDLE);
  assign m_we     = (state_q == WR);
  assign d_rvalid = rd_pipe[RD_LAT];
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: vector table, directed corner sequences, random vs. model.
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int RD_LAT = 2;
  localparam int STARVE_MAX = 8;

  logic              vga_clk, sys_rst, blank;
  logic              d_req, d_gnt, d_rvalid, w_req, w_gnt, m_en, m_we;
  logic [ADDR_W-1:0] d_addr, w_addr, m_addr;
  logic [DATA_W-1:0] d_rdata, w_data, m_wdata, m_rdata;
  logic [15:0]       w_stall_cnt;

  int errors = 0;
  int checks = 0;

  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .blank(blank),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .w_stall_cnt(w_stall_cnt)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return a[DATA_W-1:0] ^ 12'hA5A;
  endfunction

  // RAM model: unwritten words read back as pat(addr); read data appears RD_LAT cycles after issue.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] rpipe [RD_LAT];
  always @(posedge vga_clk) begin
    rpipe[0] <= mem.exists(m_addr) ? mem[m_addr] : pat(m_addr);
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    if (m_en && m_we) mem[m_addr] = m_wdata;
  end
  assign m_rdata = rpipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    blank = 1'b0; d_req = 1'b0; w_req = 1'b0;
    d_addr = '0; w_addr = '0; w_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    sys_rst = 1'b1;
    next_cycle();
    next_cycle();
    sys_rst = 1'b0;
  endtask

  typedef struct {
    logic d, w, b;
    logic eg_d, eg_w;
    int   stall;
  } vec_t;
  vec_t tv [20];

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } rd_t;

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Vector table: starts from reset state (starve = 0, stall = 0).
    tv[0]  = '{0,0,0, 0,0, 0};
    tv[1]  = '{1,0,0, 1,0, 0};
    tv[2]  = '{0,1,0, 0,1, 0};
    tv[3]  = '{1,1,0, 1,0, 0};
    tv[4]  = '{1,1,1, 1,0, 1};
    tv[5]  = '{0,1,1, 0,1, 2};
    tv[6]  = '{0,0,1, 0,0, 2};
    for (int i = 0; i < 8; i++) tv[7+i] = '{1,1,1, 1,0, 2+i};
    tv[15] = '{1,1,0, 1,0, 10};
    tv[16] = '{1,1,1, 0,1, 11};
    tv[17] = '{1,1,1, 1,0, 11};
    tv[18] = '{0,0,0, 0,0, 12};
    tv[19] = '{1,1,1, 1,0, 12};

    sys_rst = 1'b1;
    idle_inputs();
    d_req = 1'b1; w_req = 1'b1; blank = 1'b1;
    @(negedge vga_clk);
    chk("rst_d_gnt_forced", 32'(d_gnt), 32'd0);
    chk("rst_w_gnt_forced", 32'(w_gnt), 32'd0);
    next_cycle();
    do_reset();

    // Reset state
    @(negedge vga_clk);
    chk("reset_d_gnt", 32'(d_gnt), 0);
    chk("reset_w_gnt", 32'(w_gnt), 0);
    chk("reset_m_en", 32'(m_en), 0);
    chk("reset_m_we", 32'(m_we), 0);
    chk("reset_m_addr", 32'(m_addr), 0);
    chk("reset_m_wdata", 32'(m_wdata), 0);
    chk("reset_d_rvalid", 32'(d_rvalid), 0);
    chk("reset_stall", 32'(w_stall_cnt), 0);
    next_cycle();

    // T1: four back-to-back display reads
    do_reset();
    for (int k = 0; k < 8; k++) begin
      d_req = (k < 4); d_addr = ADDR_W'(k);
      @(negedge vga_clk);
      chk("t1_d_gnt", 32'(d_gnt), 32'(k < 4));
      chk("t1_m_en", 32'(m_en), 32'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) begin
        chk("t1_m_we", 32'(m_we), 0);
        chk("t1_m_addr", 32'(m_addr), 32'(k - 1));
      end
      chk("t1_d_rvalid", 32'(d_rvalid), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk("t1_d_rdata", 32'(d_rdata), 32'(pat(ADDR_W'(k - 3))));
      next_cycle();
    end

    // T2: lone write then read-back of the same address
    do_reset();
    w_req = 1'b1; w_addr = 17'h100; w_data = 12'hF00;
    @(negedge vga_clk);
    chk("t2_w_gnt", 32'(w_gnt), 1);
    chk("t2_d_gnt", 32'(d_gnt), 0);
    next_cycle();
    w_req = 1'b0;
    @(negedge vga_clk);
    chk("t2_m_en", 32'(m_en), 1);
    chk("t2_m_we", 32'(m_we), 1);
    chk("t2_m_addr", 32'(m_addr), 32'h100);
    chk("t2_m_wdata", 32'(m_wdata), 32'hF00);
    next_cycle();
    for (int k = 2; k <= 5; k++) begin
      d_req = (k == 2); d_addr = 17'h100;
      @(negedge vga_clk);
      if (k == 2) chk("t2_rd_gnt", 32'(d_gnt), 1);
      chk("t2_d_rvalid", 32'(d_rvalid), 32'(k == 5));
      if (k == 5) chk("t2_d_rdata", 32'(d_rdata), 32'hF00);
      next_cycle();
    end

    // Arbitration vector table
    do_reset();
    for (int i = 0; i < 20; i++) begin
      d_req = tv[i].d; w_req = tv[i].w; blank = tv[i].b;
      d_addr = 17'h0; w_addr = 17'h40; w_data = 12'h123;
      @(negedge vga_clk);
      chk($sformatf("tv%0d_d_gnt", i), 32'(d_gnt), 32'(tv[i].eg_d));
      chk($sformatf("tv%0d_w_gnt", i), 32'(w_gnt), 32'(tv[i].eg_w));
      chk($sformatf("tv%0d_stall", i), 32'(w_stall_cnt), 32'(tv[i].stall));
      next_cycle();
    end

    // T3: contention in active video -- writer never wins; starve saturated shows as immediate win in blanking
    do_reset();
    begin
      int wg_seen = 0;
      d_req = 1'b1; w_req = 1'b1; w_addr = 17'h80; w_data = 12'h0AA;
      for (int k = 0; k < 100; k++) begin
        @(negedge vga_clk);
        if (w_gnt !== 1'b0 || d_gnt !== 1'b1) wg_seen++;
        next_cycle();
      end
      chk("t3_writer_never_granted", 32'(wg_seen), 0);
      blank = 1'b1;
      @(negedge vga_clk);
      chk("t3_stall", 32'(w_stall_cnt), 100);
      chk("t3_forced_w_gnt", 32'(w_gnt), 1);
      next_cycle();
    end

    // T4: contention in blanking -- writer slot every STARVE_MAX+1 cycles
    do_reset();
    d_req = 1'b1; w_req = 1'b1; blank = 1'b1; w_addr = 17'h80; w_data = 12'h0BB;
    for (int c = 1; c <= 27; c++) begin
      @(negedge vga_clk);
      chk($sformatf("t4_c%0d_w_gnt", c), 32'(w_gnt), 32'(c == 9 || c == 18 || c == 27));
      chk($sformatf("t4_c%0d_d_gnt", c), 32'(d_gnt), 32'(!(c == 9 || c == 18 || c == 27)));
      next_cycle();
    end

    // T5: reset right after a read grant drops its response
    do_reset();
    d_req = 1'b1; d_addr = 17'h5;
    @(negedge vga_clk);
    chk("t5_d_gnt", 32'(d_gnt), 1);
    next_cycle();
    sys_rst = 1'b1; w_req = 1'b1;
    @(negedge vga_clk);
    chk("t5_rst_d_gnt", 32'(d_gnt), 0);
    chk("t5_rst_w_gnt", 32'(w_gnt), 0);
    next_cycle();
    sys_rst = 1'b0;
    idle_inputs();
    for (int k = 2; k <= 5; k++) begin
      @(negedge vga_clk);
      chk("t5_d_rvalid", 32'(d_rvalid), 0);
      if (k == 2) begin
        chk("t5_m_en", 32'(m_en), 0);
        chk("t5_m_we", 32'(m_we), 0);
        chk("t5_m_addr", 32'(m_addr), 0);
        chk("t5_m_wdata", 32'(m_wdata), 0);
        chk("t5_stall", 32'(w_stall_cnt), 0);
      end
      next_cycle();
    end

    // Random traffic against a transaction-level reference model
    do_reset();
    begin
      int                m_starve = 0;
      int                m_stall = 0;
      logic              e_en = 0, e_we = 0, last_wg = 0;
      logic              fw, eg_d, eg_w;
      logic [ADDR_W-1:0] e_addr = '0;
      logic [DATA_W-1:0] e_wdata = '0;
      logic [DATA_W-1:0] sh [logic [ADDR_W-1:0]];
      rd_t               q [$];
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(15) == 0) blank = ~blank;
        d_req = ($urandom_range(2) != 0);
        d_addr = 17'h200 + ADDR_W'($urandom_range(15));
        if (!w_req || last_wg) begin
          w_req  = $urandom_range(1) == 1;
          w_addr = 17'h200 + ADDR_W'($urandom_range(15));
          w_data = DATA_W'($urandom);
        end
        @(negedge vga_clk);
        fw   = w_req && d_req && blank && (m_starve == STARVE_MAX);
        eg_w = fw || (w_req && !d_req);
        eg_d = d_req && !fw;
        chk("rnd_d_gnt", 32'(d_gnt), 32'(eg_d));
        chk("rnd_w_gnt", 32'(w_gnt), 32'(eg_w));
        chk("rnd_m_en", 32'(m_en), 32'(e_en));
        chk("rnd_m_we", 32'(m_we), 32'(e_we));
        chk("rnd_m_addr", 32'(m_addr), 32'(e_addr));
        chk("rnd_m_wdata", 32'(m_wdata), 32'(e_wdata));
        chk("rnd_stall", 32'(w_stall_cnt), 32'(m_stall));
        if (q.size() > 0 && q[0].due == c) begin
          chk("rnd_d_rvalid", 32'(d_rvalid), 1);
          chk("rnd_d_rdata", 32'(d_rdata), 32'(q[0].data));
          void'(q.pop_front());
        end else begin
          chk("rnd_d_rvalid", 32'(d_rvalid), 0);
        end
        if (w_req && !eg_w && m_stall < 65535) m_stall++;
        if (eg_w || !w_req) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        e_en = eg_d || eg_w;
        e_we = eg_w;
        if (eg_d) begin
          e_addr = d_addr;
          q.push_back('{c + 1 + RD_LAT, sh.exists(d_addr) ? sh[d_addr] : pat(d_addr)});
        end
        if (eg_w) begin
          e_addr = w_addr;
          e_wdata = w_data;
          sh[w_addr] = w_data;
        end
        last_wg = eg_w;
        next_cycle();
      end
    end

    // T6: stall counter saturates at 0xFFFF
    do_reset();
    d_req = 1'b1; w_req = 1'b1; blank = 1'b0;
    for (int k = 0; k <= 65537; k++) begin
      @(negedge vga_clk);
      if (k >= 65534) chk($sformatf("t6_stall_k%0d", k), 32'(w_stall_cnt), (k == 65534) ? 32'hFFFE : 32'hFFFF);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
